// File: rtl/alu_disp_pkg.sv
// Shared definitions for the sequential ALU / BCD / 7-segment display block.
//   - opcode encodings
//   - active-low 7-segment codes {g,f,e,d,c,b,a} and a nibble encoder
//   - FSM state encoding
package alu_disp_pkg;

  localparam int unsigned NIB_W = 4;
  localparam int unsigned SEG_W = 7;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_SHL = 2'b11;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CONV_A = 3'd1,
    ST_CONV_B = 3'd2,
    ST_CONV_R = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // BCD nibble to segment code; non-decimal nibbles show blank
  function automatic logic [SEG_W-1:0] seg_encode(input logic [NIB_W-1:0] nib);
    logic [SEG_W-1:0] s;
    case (nib)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per cycle.
//   clk, rst_n : clock / async active-low reset
//   load       : capture bin_in (the first shift happens on the load edge)
//   bin_in     : BIN_W-bit value to convert
//   busy       : conversion in progress
//   valid      : one-cycle pulse once BIN_W shifts have completed
//   bcd_out    : DIGITS BCD nibbles, nibble 0 = units
module bin2bcd_seq
  import alu_disp_pkg::*;
#(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic [BIN_W-1:0]         bin_in,
  output logic                     busy,
  output logic                     valid,
  output logic [NIB_W*DIGITS-1:0]  bcd_out
);

  localparam int unsigned BCD_W = NIB_W * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  logic [BIN_W-1:0] bin_q;
  logic [BCD_W-1:0] bcd_q;
  logic [BCD_W-1:0] adj_c;
  logic [CNT_W-1:0] cnt_q;

  // add-3 correction on every nibble >= 5 before the shift
  always_comb begin
    adj_c = bcd_q;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (bcd_q[NIB_W*d +: NIB_W] >= 4'd5)
        adj_c[NIB_W*d +: NIB_W] = bcd_q[NIB_W*d +: NIB_W] + 4'd3;
    end
  end

  // The load edge doubles as shift #1: with bcd cleared no correction applies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      busy  <= 1'b0;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (load) begin
        bin_q <= {bin_in[BIN_W-2:0], 1'b0};
        bcd_q <= BCD_W'(bin_in[BIN_W-1]);
        cnt_q <= CNT_W'(1);
        busy  <= 1'b1;
      end else if (busy) begin
        bin_q <= {bin_q[BIN_W-2:0], 1'b0};
        bcd_q <= {adj_c[BCD_W-2:0], bin_q[BIN_W-1]};
        cnt_q <= cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          busy  <= 1'b0;
          valid <= 1'b1;
        end
      end
    end
  end

  assign bcd_out = bcd_q;

endmodule

// File: rtl/alu_bcd_display_seq.sv
// Clocked ALU with BCD conversion and 7-segment display drive.
//   clk, rst_n    : clock / async active-low reset
//   start, op,a,b : request and operands, accepted when busy=0
//   busy          : accept edge through done cycle inclusive
//   done          : one-cycle pulse, display/result outputs update with it
//   result, neg   : magnitude and sign (subtract only) of the last result
//   a_seg, b_seg  : operand digits, 7 bits per digit, digit 0 = units
//   r_seg         : result digits, same layout
module alu_bcd_display_seq
  import alu_disp_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned IN_DIGITS  = 2,
  parameter int unsigned OUT_DIGITS = 3,
  parameter bit          BLANK_LZ   = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [1:0]                    op,
  input  logic [WIDTH-1:0]              a,
  input  logic [WIDTH-1:0]              b,
  output logic                          busy,
  output logic                          done,
  output logic [2*WIDTH-1:0]            result,
  output logic                          neg,
  output logic [SEG_W*IN_DIGITS-1:0]    a_seg,
  output logic [SEG_W*IN_DIGITS-1:0]    b_seg,
  output logic [SEG_W*OUT_DIGITS-1:0]   r_seg
);

  localparam int unsigned RES_W     = 2 * WIDTH;
  localparam int unsigned IN_BCD_W  = NIB_W * IN_DIGITS;
  localparam int unsigned OUT_BCD_W = NIB_W * OUT_DIGITS;

  localparam longint unsigned IN_MAX  = (64'd1 << WIDTH) - 64'd1;
  localparam longint unsigned RES_MAX = (64'd1 << RES_W) - 64'd1;
  localparam longint unsigned IN_LIM  = 64'd10 ** IN_DIGITS;
  localparam longint unsigned OUT_LIM = 64'd10 ** OUT_DIGITS;

  // parameter sanity: every value must fit the digits provided
  if (WIDTH < 2) begin : g_chk_width
    $error("alu_bcd_display_seq: WIDTH must be >= 2");
  end
  if (IN_LIM <= IN_MAX) begin : g_chk_in_digits
    $error("alu_bcd_display_seq: IN_DIGITS too small for WIDTH");
  end
  if (OUT_LIM <= RES_MAX) begin : g_chk_out_digits
    $error("alu_bcd_display_seq: OUT_DIGITS too small for 2*WIDTH");
  end
  if (IN_DIGITS > OUT_DIGITS) begin : g_chk_digit_order
    $error("alu_bcd_display_seq: IN_DIGITS must not exceed OUT_DIGITS");
  end

  state_t state_q, state_c;

  logic [WIDTH-1:0]     b_q;
  logic [RES_W-1:0]     res_q;
  logic                 neg_q;
  logic [IN_BCD_W-1:0]  a_bcd_q, b_bcd_q;
  logic [OUT_BCD_W-1:0] r_bcd_q;

  logic                 accept_c;
  logic [WIDTH-1:0]     shamt_c;
  logic [RES_W-1:0]     res_c;
  logic                 conv_load_c;
  logic [RES_W-1:0]     conv_bin_c;
  logic                 conv_busy, conv_valid;
  logic [OUT_BCD_W-1:0] conv_bcd;

  logic [SEG_W*IN_DIGITS-1:0]  a_seg_c, b_seg_c;
  logic [SEG_W*OUT_DIGITS-1:0] r_seg_c;
  logic                        lit_a_c, lit_b_c, lit_r_c;

  assign accept_c = (state_q == ST_IDLE) && start && !busy && !conv_busy;

  // ALU; every result fits RES_W so no overflow handling is needed
  always_comb begin
    shamt_c = WIDTH'(32'(b) % WIDTH);
    res_c   = '0;
    case (op)
      OP_ADD: res_c = RES_W'(a) + RES_W'(b);
      OP_SUB: res_c = (a >= b) ? RES_W'(a) - RES_W'(b) : RES_W'(b) - RES_W'(a);
      OP_MUL: res_c = RES_W'(a) * RES_W'(b);
      OP_SHL: res_c = RES_W'(a) << shamt_c;
      default: res_c = '0;
    endcase
  end

  // next state; each conversion phase ends on the converter valid pulse,
  // which is also the load edge of the next phase
  always_comb begin
    state_c     = state_q;
    conv_load_c = 1'b0;
    conv_bin_c  = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          state_c     = ST_CONV_A;
          conv_load_c = 1'b1;
          conv_bin_c  = RES_W'(a);
        end
      end
      ST_CONV_A: begin
        if (conv_valid) begin
          state_c     = ST_CONV_B;
          conv_load_c = 1'b1;
          conv_bin_c  = RES_W'(b_q);
        end
      end
      ST_CONV_B: begin
        if (conv_valid) begin
          state_c     = ST_CONV_R;
          conv_load_c = 1'b1;
          conv_bin_c  = res_q;
        end
      end
      ST_CONV_R: begin
        if (conv_valid) state_c = ST_DONE;
      end
      ST_DONE: state_c = ST_IDLE;
      default: state_c = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_c;
  end

  bin2bcd_seq #(
    .BIN_W  (RES_W),
    .DIGITS (OUT_DIGITS)
  ) u_bin2bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (conv_load_c),
    .bin_in  (conv_bin_c),
    .busy    (conv_busy),
    .valid   (conv_valid),
    .bcd_out (conv_bcd)
  );

  // digit encode with optional leading-zero blanking, scanned MSD first
  always_comb begin
    a_seg_c = '1;
    b_seg_c = '1;
    r_seg_c = '1;
    lit_a_c = !BLANK_LZ;
    lit_b_c = !BLANK_LZ;
    lit_r_c = !BLANK_LZ;
    for (int k = int'(IN_DIGITS) - 1; k >= 0; k--) begin
      if (a_bcd_q[NIB_W*k +: NIB_W] != 4'd0 || k == 0) lit_a_c = 1'b1;
      if (b_bcd_q[NIB_W*k +: NIB_W] != 4'd0 || k == 0) lit_b_c = 1'b1;
      if (lit_a_c) a_seg_c[SEG_W*k +: SEG_W] = seg_encode(a_bcd_q[NIB_W*k +: NIB_W]);
      if (lit_b_c) b_seg_c[SEG_W*k +: SEG_W] = seg_encode(b_bcd_q[NIB_W*k +: NIB_W]);
    end
    for (int k = int'(OUT_DIGITS) - 1; k >= 0; k--) begin
      if (r_bcd_q[NIB_W*k +: NIB_W] != 4'd0 || k == 0) lit_r_c = 1'b1;
      if (lit_r_c) r_seg_c[SEG_W*k +: SEG_W] = seg_encode(r_bcd_q[NIB_W*k +: NIB_W]);
    end
  end

  // operand/result capture, BCD capture and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_q     <= '0;
      res_q   <= '0;
      neg_q   <= 1'b0;
      a_bcd_q <= '0;
      b_bcd_q <= '0;
      r_bcd_q <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      neg     <= 1'b0;
      a_seg   <= '1;
      b_seg   <= '1;
      r_seg   <= '1;
    end else begin
      done <= 1'b0;
      if (accept_c) begin
        b_q   <= b;
        res_q <= res_c;
        neg_q <= (op == OP_SUB) && (a < b);
        busy  <= 1'b1;
      end
      if (done) busy <= 1'b0;
      case (state_q)
        ST_CONV_A: if (conv_valid) a_bcd_q <= conv_bcd[IN_BCD_W-1:0];
        ST_CONV_B: if (conv_valid) b_bcd_q <= conv_bcd[IN_BCD_W-1:0];
        ST_CONV_R: if (conv_valid) r_bcd_q <= conv_bcd;
        ST_DONE: begin
          done   <= 1'b1;
          result <= res_q;
          neg    <= neg_q;
          a_seg  <= a_seg_c;
          b_seg  <= b_seg_c;
          r_seg  <= r_seg_c;
        end
        default: ;
      endcase
    end
  end

endmodule
